// File: rtl/mux_4_1_scan_ctrl_if.sv
// Valid/ready bundle for the scan controller: parallel word in, serial bit stream out.
// master is the environment side, slave is the controller side.
interface mux_4_1_scan_ctrl_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       ser_valid;
   logic       ser_ready;
   logic       ser_bit;
   logic       ser_last;

   modport master (
      output in_valid, in_data, ser_ready,
      input  in_ready, ser_valid, ser_bit, ser_last
   );

   modport slave (
      input  in_valid, in_data, ser_ready,
      output in_ready, ser_valid, ser_bit, ser_last
   );
endinterface

// File: rtl/mux_4_1_scan_ctrl.sv
// Serializer around a 4:1 mux: latches a 4-bit word onto the mux inputs and walks the select
// through all four codes, returning the mux output as a valid/ready serial stream.
module mux_4_1_scan_ctrl #(
   parameter bit          MSB_FIRST = 1'b0,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   mux_4_1_scan_ctrl_if.slave   bus,
   output logic [3:0]           mux_i,
   output logic [1:0]           s,
   input  logic                 y_in,
   output logic                 busy,
   output logic [CNT_W-1:0]     word_count
);

   localparam logic [1:0] SelStart = MSB_FIRST ? 2'b11 : 2'b00;
   localparam logic [1:0] SelEnd   = MSB_FIRST ? 2'b00 : 2'b11;

   typedef enum logic {StIdle, StShift} state_e;

   state_e           state_q, state_d;
   logic [3:0]       word_q, word_d;
   logic [1:0]       sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         word_q  <= 4'b0000;
         sel_q   <= SelStart;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               word_d  = bus.in_data;
               sel_d   = SelStart;
               state_d = StShift;
            end
         end
         StShift: begin
            // Without ser_ready everything holds, which keeps the bit stable under backpressure.
            if (bus.ser_ready) begin
               if (sel_q == SelEnd) begin
                  state_d = StIdle;
                  sel_d   = SelStart;
                  cnt_d   = cnt_q + CNT_W'(1);
               end else begin
                  sel_d = MSB_FIRST ? sel_q - 2'd1 : sel_q + 2'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.ser_valid = (state_q == StShift);
   assign bus.ser_bit   = y_in;
   assign bus.ser_last  = (state_q == StShift) && (sel_q == SelEnd);
   assign busy          = (state_q == StShift);
   assign mux_i         = word_q;
   assign s             = sel_q;
   assign word_count    = cnt_q;

endmodule

// File: tb/tb_mux_4_1_scan_ctrl.sv
// Randomized scoreboard bench: one LSB-first instance with a 2-bit counter and one MSB-first
// instance with an 8-bit counter, each paired with a behavioural 4:1 mux.
module tb_mux_4_1_scan_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [3:0] word;
      logic [1:0] sel;
      logic       b;
      logic       last;
   } exp_t;

   task automatic check(input int inst, input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL inst%0d %s: got %0d expected %0d at %0t", inst, name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam bit          Msb   = (g == 1);
      localparam int unsigned Cw    = (g == 0) ? 2 : 8;
      localparam logic [1:0]  Start = Msb ? 2'b11 : 2'b00;

      logic          rst;
      logic [3:0]    mux_i;
      logic [1:0]    s;
      logic          y_in;
      logic          busy;
      logic [Cw-1:0] word_count;
      logic          done;
      exp_t          q[$];

      mux_4_1_scan_ctrl_if bus ();

      assign y_in = mux_i[s];

      mux_4_1_scan_ctrl #(
         .MSB_FIRST (Msb),
         .CNT_W     (Cw)
      ) dut (
         .clk        (clk),
         .rst        (rst),
         .bus        (bus),
         .mux_i      (mux_i),
         .s          (s),
         .y_in       (y_in),
         .busy       (busy),
         .word_count (word_count)
      );

      // Driver: random words and random backpressure, one mid-word reset.
      initial begin
         bit did_reset = 1'b0;
         done          = 1'b0;
         rst           = 1'b1;
         bus.in_valid  = 1'b0;
         bus.in_data   = 4'h0;
         bus.ser_ready = 1'b0;
         repeat (2) @(posedge clk);
         #1 rst = 1'b0;
         for (int it = 0; it < 600; it++) begin
            if (it >= 300 && !did_reset && busy) begin
               did_reset    = 1'b1;
               rst          = 1'b1;
               bus.in_valid = 1'b0;
               q.delete();
               repeat (2) @(posedge clk);
               #1 rst = 1'b0;
            end
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = 4'($urandom);
            bus.ser_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
               for (int k = 0; k < 4; k++) begin
                  int idx;
                  exp_t e;
                  idx    = Msb ? 3 - k : k;
                  e.word = bus.in_data;
                  e.sel  = 2'(idx);
                  e.b    = bus.in_data[idx];
                  e.last = (k == 3);
                  q.push_back(e);
               end
            end
            @(posedge clk);
            #1;
         end
         bus.in_valid  = 1'b0;
         bus.ser_ready = 1'b1;
         repeat (8) @(posedge clk);
         #1;
         check(g, "queue_drained", q.size(), 0);
         done = 1'b1;
      end

      // Monitor: independent state model plus scoreboard pops on each accepted bit.
      bit         exp_shift = 1'b0;
      int         exp_cnt   = 0;
      logic [3:0] last_word = 4'h0;
      bit         stall     = 1'b0;
      logic [1:0] prev_s;
      logic       prev_bit, prev_last;
      logic [3:0] prev_mux;

      always @(negedge clk) begin
         if (rst) begin
            exp_shift = 1'b0;
            exp_cnt   = 0;
            last_word = 4'h0;
            stall     = 1'b0;
         end else if (!done) begin
            check(g, "in_ready", int'(bus.in_ready), int'(!exp_shift));
            check(g, "ser_valid", int'(bus.ser_valid), int'(exp_shift));
            check(g, "busy", int'(busy), int'(exp_shift));
            check(g, "word_count", int'(word_count), exp_cnt);
            if (!exp_shift) begin
               check(g, "idle_s", int'(s), int'(Start));
               check(g, "idle_mux_i", int'(mux_i), int'(last_word));
               check(g, "idle_ser_last", int'(bus.ser_last), 0);
               if (bus.in_valid) exp_shift = 1'b1;
            end else begin
               if (stall) begin
                  check(g, "hold_s", int'(s), int'(prev_s));
                  check(g, "hold_bit", int'(bus.ser_bit), int'(prev_bit));
                  check(g, "hold_last", int'(bus.ser_last), int'(prev_last));
                  check(g, "hold_mux_i", int'(mux_i), int'(prev_mux));
               end
               prev_s    = s;
               prev_bit  = bus.ser_bit;
               prev_last = bus.ser_last;
               prev_mux  = mux_i;
               stall     = !bus.ser_ready;
               if (q.size() == 0) begin
                  check(g, "scoreboard_nonempty", 0, 1);
               end else begin
                  exp_t e;
                  e = q[0];
                  check(g, "s", int'(s), int'(e.sel));
                  check(g, "ser_bit", int'(bus.ser_bit), int'(e.b));
                  check(g, "ser_last", int'(bus.ser_last), int'(e.last));
                  check(g, "mux_i", int'(mux_i), int'(e.word));
                  if (bus.ser_ready) begin
                     void'(q.pop_front());
                     if (e.last) begin
                        exp_shift = 1'b0;
                        exp_cnt   = (exp_cnt + 1) % (1 << Cw);
                        last_word = e.word;
                        stall     = 1'b0;
                     end
                  end
               end
            end
         end
      end
   end

   initial begin
      int cyc = 0;
      while (!(g_inst[0].done && g_inst[1].done) && cyc < 10000) begin
         @(posedge clk);
         cyc++;
      end
      check(0, "completion_timeout", int'(cyc >= 10000), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
